// File: rtl/kernel_launcher_pkg.sv
// Shared types and helpers for the kernel launcher: FSM state encoding and
// the word-slice offset used to address the packed array images.
package kernel_launcher_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      RUN,
      DRAIN,
      OUT
   } state_t;

   function automatic int word_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/kernel_launcher_if.sv
// Job/result handshakes plus the kernel control and array back-door port.
// master = launcher side, slave = host/kernel side.
interface kernel_launcher_if #(
   parameter int ADDR_W = 1,
   parameter int DATA_W = 1,
   parameter int INIT_W = 1,
   parameter int RES_W  = 2,
   parameter int CNT_W  = 16
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int MEM_W = DEPTH * DATA_W;

   logic              job_valid;
   logic              job_ready;
   logic [INIT_W-1:0] job_init;
   logic [MEM_W-1:0]  job_mem;

   logic              res_valid;
   logic              res_ready;
   logic [RES_W-1:0]  res_value;
   logic [MEM_W-1:0]  res_mem;
   logic [CNT_W-1:0]  res_cycles;
   logic              res_timeout;

   logic              k_r_enable;
   logic [INIT_W-1:0] k_init;
   logic              k_w_enable;
   logic [RES_W-1:0]  k_result;
   logic              k_control_arr;
   logic              k_arr_we;
   logic [ADDR_W-1:0] k_arr_addr;
   logic [DATA_W-1:0] k_arr_wdata;
   logic [DATA_W-1:0] k_arr_rdata;

   modport master (
      input  job_valid, job_init, job_mem, res_ready,
      input  k_w_enable, k_result, k_arr_rdata,
      output job_ready, res_valid, res_value, res_mem, res_cycles, res_timeout,
      output k_r_enable, k_init, k_control_arr, k_arr_we, k_arr_addr, k_arr_wdata
   );

   modport slave (
      output job_valid, job_init, job_mem, res_ready,
      output k_w_enable, k_result, k_arr_rdata,
      input  job_ready, res_valid, res_value, res_mem, res_cycles, res_timeout,
      input  k_r_enable, k_init, k_control_arr, k_arr_we, k_arr_addr, k_arr_wdata
   );

endinterface

// File: rtl/launcher_timer.sv
// Saturating RUN-cycle counter. count_next is the count including the current
// cycle; expired flags that it has reached TIMEOUT (never when TIMEOUT is 0).
module launcher_timer #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count_next,
   output logic             expired
);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [CNT_W-1:0] count;

   assign count_next = (count == '1) ? count : count + ONE;
   assign expired    = (TIMEOUT != 0) && (count_next == LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count_next;
      end
   end

endmodule

// File: rtl/kernel_launcher.sv
// Host-side driver for a synthesized kernel: preloads its array, pulses start,
// waits for done (with timeout), reads the array back and returns the result.
module kernel_launcher #(
   parameter int ADDR_W  = 1,
   parameter int DATA_W  = 1,
   parameter int INIT_W  = 1,
   parameter int RES_W   = 2,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1000
) (
   input logic               clk,
   input logic               rst_n,
   kernel_launcher_if.master bus
);
   import kernel_launcher_pkg::*;

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int MEM_W = DEPTH * DATA_W;
   localparam logic [ADDR_W:0]  LOAD_LAST   = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0]  DRAIN_LAST  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]  IDX_ONE     = (ADDR_W + 1)'(1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   state_t            state;
   state_t            next_state;
   logic [ADDR_W:0]   idx;
   logic [INIT_W-1:0] init_q;
   logic [MEM_W-1:0]  mem_q;
   logic [MEM_W-1:0]  res_mem_q;
   logic [RES_W-1:0]  res_value_q;
   logic [CNT_W-1:0]  res_cycles_q;
   logic              res_timeout_q;
   logic [CNT_W-1:0]  cnt_next;
   logic              cnt_expired;

   launcher_timer #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (state == START),
      .enable     (state == RUN),
      .count_next (cnt_next),
      .expired    (cnt_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A done in the same cycle as the timeout limit is treated as a real done.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.job_valid) next_state = LOAD;
         LOAD:    if (idx == LOAD_LAST) next_state = START;
         START:   next_state = RUN;
         RUN:     if (bus.k_w_enable || cnt_expired) next_state = DRAIN;
         DRAIN:   if (idx == DRAIN_LAST) next_state = OUT;
         OUT:     if (bus.res_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.job_ready     = rst_n && (state == IDLE);
      bus.res_valid     = (state == OUT);
      bus.res_value     = res_value_q;
      bus.res_mem       = res_mem_q;
      bus.res_cycles    = res_cycles_q;
      bus.res_timeout   = res_timeout_q;
      bus.k_r_enable    = (state == START);
      bus.k_init        = '0;
      bus.k_control_arr = (state == LOAD) || (state == DRAIN);
      bus.k_arr_we      = (state == LOAD);
      bus.k_arr_addr    = '0;
      bus.k_arr_wdata   = '0;
      if ((state == START) || (state == RUN)) begin
         bus.k_init = init_q;
      end
      if (bus.k_control_arr) begin
         bus.k_arr_addr = idx[ADDR_W-1:0];
      end
      if (state == LOAD) begin
         bus.k_arr_wdata = mem_q[word_lsb(int'(idx[ADDR_W-1:0]), DATA_W) +: DATA_W];
      end
   end

   // DRAIN runs one cycle longer than LOAD because read data lags its address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx           <= '0;
         init_q        <= '0;
         mem_q         <= '0;
         res_mem_q     <= '0;
         res_value_q   <= '0;
         res_cycles_q  <= '0;
         res_timeout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.job_valid) begin
                  init_q <= bus.job_init;
                  mem_q  <= bus.job_mem;
                  idx    <= '0;
               end
            end
            LOAD:  idx <= idx + IDX_ONE;
            START: idx <= '0;
            RUN: begin
               if (bus.k_w_enable) begin
                  res_value_q   <= bus.k_result;
                  res_cycles_q  <= cnt_next;
                  res_timeout_q <= 1'b0;
               end else if (cnt_expired) begin
                  res_value_q   <= '0;
                  res_cycles_q  <= TIMEOUT_CNT;
                  res_timeout_q <= 1'b1;
               end
            end
            DRAIN: begin
               if (idx != '0) begin
                  res_mem_q[word_lsb(int'(idx) - 1, DATA_W) +: DATA_W] <= bus.k_arr_rdata;
               end
               idx <= idx + IDX_ONE;
            end
            default: ;
         endcase
      end
   end

endmodule
